// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone arbiter for the 8-bit data, 24-bit address bus.
// Master 0 is the CPU core, master 1 the UART debug bridge. Ties are broken
// round-robin, the grant is held for the whole bus cycle (cyc), and a watchdog
// force-terminates strobes that the slave never acknowledges.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT = 16,     // unacked stb cycles before forced end; 0 = off
    parameter logic [7:0]  TO_DATA = 8'hFF   // read data returned on a forced end
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    // master 0 (CPU)
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [23:0] i_m0_addr,
    input  logic [7:0]  i_m0_dat,
    output logic [7:0]  o_m0_dat,
    output logic        o_m0_ack,
    // master 1 (debug bridge)
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [23:0] i_m1_addr,
    input  logic [7:0]  i_m1_dat,
    output logic [7:0]  o_m1_dat,
    output logic        o_m1_ack,
    // slave
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [23:0] o_s_addr,
    output logic [7:0]  o_s_dat,
    input  logic [7:0]  i_s_dat,
    input  logic        i_s_ack,
    // status
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    input  logic        i_timeout_clr
);

    // Watchdog counter only needs to reach TIMEOUT-1.
    localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned   WD_MAX  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] WD_LAST = CW'(WD_MAX);
    localparam bit            WD_EN   = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;   // 0 = master 0, 1 = master 1
    logic          r_last,  w_last_nxt;    // master served most recently
    logic [CW-1:0] r_wd,    w_wd_nxt;
    logic          r_timeout;

    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_own_we;
    logic [23:0]   w_own_addr;
    logic [7:0]    w_own_dat;
    logic          w_expire;

    // Route the current owner's request signals onto one set of wires.
    always_comb begin
        if (r_owner) begin
            w_own_cyc  = i_m1_cyc;
            w_own_stb  = i_m1_stb;
            w_own_we   = i_m1_we;
            w_own_addr = i_m1_addr;
            w_own_dat  = i_m1_dat;
        end else begin
            w_own_cyc  = i_m0_cyc;
            w_own_stb  = i_m0_stb;
            w_own_we   = i_m0_we;
            w_own_addr = i_m0_addr;
            w_own_dat  = i_m0_dat;
        end
    end

    // Expiry fires in the same cycle the counter reaches its last value with the
    // strobe still unanswered; a real ack in that cycle takes precedence.
    assign w_expire = WD_EN && (r_state == ST_OWN) && w_own_cyc && w_own_stb &&
                      !i_s_ack && (r_wd == WD_LAST);

    // Next-state, owner, last-served and watchdog count.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_wd_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    w_owner_nxt = ~r_last;
                    w_state_nxt = ST_OWN;
                end else if (i_m0_cyc) begin
                    w_owner_nxt = 1'b0;
                    w_state_nxt = ST_OWN;
                end else if (i_m1_cyc) begin
                    w_owner_nxt = 1'b1;
                    w_state_nxt = ST_OWN;
                end
            end
            ST_OWN: begin
                if (!w_own_cyc) begin
                    // Always pass through IDLE so the other master gets a fair look.
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                end else if (w_expire) begin
                    w_state_nxt = ST_ABORT;
                end else if (w_own_stb && !i_s_ack) begin
                    w_wd_nxt = r_wd + CW'(1);
                end
            end
            ST_ABORT: begin
                // Slave is cut off; wait for the owner to close its cycle.
                if (!w_own_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; the last-served reset value makes master 0 win the first tie.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_wd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_wd    <= w_wd_nxt;
        end
    end

    // Sticky timeout flag; a new expiry beats a simultaneous clear.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_expire) begin
            r_timeout <= 1'b1;
        end else if (i_timeout_clr) begin
            r_timeout <= 1'b0;
        end
    end

    // Flag is visible already in the expiry cycle itself.
    assign o_timeout = r_timeout | w_expire;

    // Bus-side outputs: everything quiet unless a master owns the bus.
    always_comb begin
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_we   = 1'b0;
        o_s_addr = '0;
        o_s_dat  = '0;
        o_m0_ack = 1'b0;
        o_m1_ack = 1'b0;
        o_m0_dat = '0;
        o_m1_dat = '0;
        o_grant  = 2'b00;
        if (r_state != ST_IDLE) begin
            o_grant = r_owner ? 2'b10 : 2'b01;
        end
        if (r_state == ST_OWN) begin
            o_s_cyc  = w_own_cyc & ~w_expire;
            o_s_stb  = w_own_stb & ~w_expire;
            o_s_we   = w_own_we;
            o_s_addr = w_own_addr;
            o_s_dat  = w_own_dat;
            o_m0_dat = i_s_dat;
            o_m1_dat = i_s_dat;
            if (r_owner) begin
                o_m1_ack = i_s_ack | w_expire;
                if (w_expire) begin
                    o_m1_dat = TO_DATA;
                end
            end else begin
                o_m0_ack = i_s_ack | w_expire;
                if (w_expire) begin
                    o_m0_dat = TO_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Bench for wb_arbiter2: a vector table for basic arbitration, hand-written
// sequences for the multi-cycle corners, then random traffic against a
// transaction-level reference model. Two instances: watchdog 16 and watchdog off.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc, m0_stb, m0_we;
    logic [23:0] m0_addr;
    logic [7:0]  m0_dat;
    logic        m1_cyc, m1_stb, m1_we;
    logic [23:0] m1_addr;
    logic [7:0]  m1_dat;
    logic [7:0]  s_dat;
    logic        s_ack;
    logic        to_clr;

    logic [7:0]  a_m0_dat, a_m1_dat, b_m0_dat, b_m1_dat;
    logic        a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack;
    logic        a_s_cyc, a_s_stb, a_s_we, b_s_cyc, b_s_stb, b_s_we;
    logic [23:0] a_s_addr, b_s_addr;
    logic [7:0]  a_s_dat, b_s_dat;
    logic [1:0]  a_grant, b_grant;
    logic        a_to, b_to;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT(16), .TO_DATA(8'hFF)) u_a (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_dat(m0_dat), .o_m0_dat(a_m0_dat), .o_m0_ack(a_m0_ack),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_dat(m1_dat), .o_m1_dat(a_m1_dat), .o_m1_ack(a_m1_ack),
        .o_s_cyc(a_s_cyc), .o_s_stb(a_s_stb), .o_s_we(a_s_we), .o_s_addr(a_s_addr),
        .o_s_dat(a_s_dat), .i_s_dat(s_dat), .i_s_ack(s_ack),
        .o_grant(a_grant), .o_timeout(a_to), .i_timeout_clr(to_clr)
    );

    wb_arbiter2 #(.TIMEOUT(0), .TO_DATA(8'hFF)) u_b (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_dat(m0_dat), .o_m0_dat(b_m0_dat), .o_m0_ack(b_m0_ack),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_dat(m1_dat), .o_m1_dat(b_m1_dat), .o_m1_ack(b_m1_ack),
        .o_s_cyc(b_s_cyc), .o_s_stb(b_s_stb), .o_s_we(b_s_we), .o_s_addr(b_s_addr),
        .o_s_dat(b_s_dat), .i_s_dat(s_dat), .i_s_ack(s_ack),
        .o_grant(b_grant), .o_timeout(b_to), .i_timeout_clr(to_clr)
    );

    typedef struct {
        logic [1:0]  grant;
        logic        scyc, sstb, swe;
        logic [23:0] saddr;
        logic [7:0]  sdat;
        logic        ack0, ack1;
        logic [7:0]  d0, d1;
        logic        to;
    } obs_t;

    obs_t oa, ob;
    always_comb oa = '{a_grant, a_s_cyc, a_s_stb, a_s_we, a_s_addr, a_s_dat,
                       a_m0_ack, a_m1_ack, a_m0_dat, a_m1_dat, a_to};
    always_comb ob = '{b_grant, b_s_cyc, b_s_stb, b_s_we, b_s_addr, b_s_dat,
                       b_m0_ack, b_m1_ack, b_m0_dat, b_m1_dat, b_to};

    // Reference model: who holds the bus, whether it was cut off, how many
    // strobe cycles in a row have gone unanswered, and the sticky flag.
    typedef struct {
        int owner;     // -1 = nobody
        bit cut;
        int last;
        int unanswered;
        bit flag;
    } mdl_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
        chk({t, ".grant"}, 32'(a.grant), 32'(e.grant));
        chk({t, ".s_cyc"}, 32'(a.scyc),  32'(e.scyc));
        chk({t, ".s_stb"}, 32'(a.sstb),  32'(e.sstb));
        chk({t, ".s_we"},  32'(a.swe),   32'(e.swe));
        chk({t, ".s_addr"},32'(a.saddr), 32'(e.saddr));
        chk({t, ".s_dat"}, 32'(a.sdat),  32'(e.sdat));
        chk({t, ".m0_ack"},32'(a.ack0),  32'(e.ack0));
        chk({t, ".m1_ack"},32'(a.ack1),  32'(e.ack1));
        chk({t, ".m0_dat"},32'(a.d0),    32'(e.d0));
        chk({t, ".m1_dat"},32'(a.d1),    32'(e.d1));
        chk({t, ".timeout"},32'(a.to),   32'(e.to));
    endtask

    function automatic void model_eval(input mdl_t m, input int t, output obs_t o, output mdl_t n);
        bit c[2]; bit s[2]; bit w[2];
        logic [23:0] ad[2];
        logic [7:0]  dt[2];
        bit fire;
        int p;
        c[0] = m0_cyc; s[0] = m0_stb; w[0] = m0_we; ad[0] = m0_addr; dt[0] = m0_dat;
        c[1] = m1_cyc; s[1] = m1_stb; w[1] = m1_we; ad[1] = m1_addr; dt[1] = m1_dat;
        o = '{default: '0};
        n = m;
        fire = 1'b0;
        p = m.owner;
        if (p >= 0) o.grant = (p == 0) ? 2'b01 : 2'b10;
        if (p >= 0 && !m.cut) begin
            // this is the t-th unanswered strobe in a row -> cut off
            fire = (t > 0) && c[p] && s[p] && !s_ack && (m.unanswered + 1 == t);
            o.scyc  = c[p] && !fire;
            o.sstb  = s[p] && !fire;
            o.swe   = w[p];
            o.saddr = ad[p];
            o.sdat  = dt[p];
            o.d0 = s_dat;
            o.d1 = s_dat;
            if (p == 0) begin
                o.ack0 = s_ack || fire;
                if (fire) o.d0 = 8'hFF;
            end else begin
                o.ack1 = s_ack || fire;
                if (fire) o.d1 = 8'hFF;
            end
        end
        o.to = m.flag || fire;
        if (p < 0) begin
            if (c[0] && c[1]) n.owner = 1 - m.last;
            else if (c[0])    n.owner = 0;
            else if (c[1])    n.owner = 1;
        end else if (!c[p]) begin
            n.last = p; n.owner = -1; n.cut = 1'b0; n.unanswered = 0;
        end else if (!m.cut) begin
            if (fire)                n.cut = 1'b1;
            if (fire)                n.unanswered = 0;
            else if (s[p] && !s_ack) n.unanswered = m.unanswered + 1;
            else                     n.unanswered = 0;
        end
        n.flag = fire ? 1'b1 : (to_clr ? 1'b0 : m.flag);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_dat = 8'h00;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_dat = 8'h00;
        m0_addr = 24'hABCDEF; m1_addr = 24'h000123;
        s_ack = 0; s_dat = 8'h00; to_clr = 0;
    endtask

    typedef struct {
        logic m0c, m0s, m1c, m1s, ack;
        logic [7:0] sd;
        logic [1:0] g;
        logic sc, a0, a1;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[16];
    bit   rc[2];
    mdl_t ma, mb, na, nb;
    obs_t ea, eb;

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nacks, nbadg, mode;

        // single m1 read, then tie/alternation
        tbl[0]  = '{0,0,1,1,0,8'h00, 2'b00,0,0,0,8'h00};
        tbl[1]  = '{0,0,1,1,0,8'h00, 2'b10,1,0,0,8'h00};
        tbl[2]  = '{0,0,1,1,0,8'h00, 2'b10,1,0,0,8'h00};
        tbl[3]  = '{0,0,1,1,1,8'h5A, 2'b10,1,0,1,8'h5A};
        tbl[4]  = '{0,0,0,0,0,8'h00, 2'b10,0,0,0,8'h00};
        tbl[5]  = '{0,0,0,0,0,8'h00, 2'b00,0,0,0,8'h00};
        tbl[6]  = '{1,1,1,1,0,8'h00, 2'b00,0,0,0,8'h00};
        tbl[7]  = '{1,1,1,1,1,8'h33, 2'b01,1,1,0,8'h33};
        tbl[8]  = '{0,0,1,1,0,8'h00, 2'b01,0,0,0,8'h00};
        tbl[9]  = '{0,0,1,1,0,8'h00, 2'b00,0,0,0,8'h00};
        tbl[10] = '{0,0,1,1,1,8'h44, 2'b10,1,0,1,8'h44};
        tbl[11] = '{0,0,0,0,0,8'h00, 2'b10,0,0,0,8'h00};
        tbl[12] = '{1,1,1,1,0,8'h00, 2'b00,0,0,0,8'h00};
        tbl[13] = '{1,1,1,1,1,8'h66, 2'b01,1,1,0,8'h66};
        tbl[14] = '{0,0,0,0,0,8'h00, 2'b01,0,0,0,8'h00};
        tbl[15] = '{0,0,0,0,0,8'h00, 2'b00,0,0,0,8'h00};

        // reset state, with requests and ack already driven
        idle_in();
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.grant", 32'(a_grant), 0);
        chk("rst.s_cyc", 32'(a_s_cyc), 0);
        chk("rst.m0_ack", 32'(a_m0_ack), 0);
        chk("rst.timeout", 32'(a_to), 0);
        idle_in();
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            m0_cyc = tbl[i].m0c; m0_stb = tbl[i].m0s;
            m1_cyc = tbl[i].m1c; m1_stb = tbl[i].m1s;
            s_ack = tbl[i].ack; s_dat = tbl[i].sd;
            #1;
            chk($sformatf("tbl%0d.grant", i), 32'(a_grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d.s_cyc", i), 32'(a_s_cyc), 32'(tbl[i].sc));
            chk($sformatf("tbl%0d.m0_ack", i), 32'(a_m0_ack), 32'(tbl[i].a0));
            chk($sformatf("tbl%0d.m1_ack", i), 32'(a_m1_ack), 32'(tbl[i].a1));
            chk($sformatf("tbl%0d.timeout", i), 32'(a_to), 0);
            if (tbl[i].a0) chk($sformatf("tbl%0d.m0_dat", i), 32'(a_m0_dat), 32'(tbl[i].d));
            if (tbl[i].a1) chk($sformatf("tbl%0d.m1_dat", i), 32'(a_m1_dat), 32'(tbl[i].d));
            if (tbl[i].sc)
                chk($sformatf("tbl%0d.s_addr", i), 32'(a_s_addr),
                    (tbl[i].g == 2'b10) ? 32'h000123 : 32'hABCDEF);
            tick();
        end

        // grant hold: m0 writes 0x10..0x12 while m1 keeps requesting
        idle_in();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_dat = 8'h10;
        #1 chk("hold.idle_grant", 32'(a_grant), 0);
        tick();
        m1_cyc = 1; m1_stb = 1;
        for (int k = 0; k < 3; k++) begin
            m0_stb = 1; m0_dat = 8'h10 + 8'(k); s_ack = 1;
            #1;
            chk($sformatf("hold.w%0d.grant", k), 32'(a_grant), 32'h1);
            chk($sformatf("hold.w%0d.s_we", k), 32'(a_s_we), 1);
            chk($sformatf("hold.w%0d.s_dat", k), 32'(a_s_dat), 32'h10 + k);
            chk($sformatf("hold.w%0d.m0_ack", k), 32'(a_m0_ack), 1);
            chk($sformatf("hold.w%0d.m1_ack", k), 32'(a_m1_ack), 0);
            tick();
            if (k == 0) begin
                m0_stb = 0; s_ack = 0;
                #1;
                chk("hold.gap.grant", 32'(a_grant), 32'h1);
                chk("hold.gap.s_cyc", 32'(a_s_cyc), 1);
                chk("hold.gap.s_stb", 32'(a_s_stb), 0);
                tick();
            end
        end
        m0_cyc = 0; m0_stb = 0; m0_we = 0; s_ack = 0;
        #1 chk("hold.drop.grant", 32'(a_grant), 32'h1);
        tick();
        #1 chk("hold.dead.grant", 32'(a_grant), 0);
        tick();
        #1 chk("hold.m1.grant", 32'(a_grant), 32'h2);
        chk("hold.m1.s_addr", 32'(a_s_addr), 32'h000123);
        tick();
        m1_cyc = 0; m1_stb = 0;
        tick(); tick();

        // watchdog: m1 read, slave silent
        idle_in();
        m1_cyc = 1; m1_stb = 1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk($sformatf("wd.b.c%0d.m1_ack", k), 32'(b_m1_ack), 0);
            if (k < 16) begin
                chk($sformatf("wd.c%0d.m1_ack", k), 32'(a_m1_ack), 0);
                chk($sformatf("wd.c%0d.s_cyc", k), 32'(a_s_cyc), 1);
            end else begin
                chk("wd.fire.m1_ack", 32'(a_m1_ack), 1);
                chk("wd.fire.m1_dat", 32'(a_m1_dat), 32'hFF);
                chk("wd.fire.s_cyc", 32'(a_s_cyc), 0);
                chk("wd.fire.s_stb", 32'(a_s_stb), 0);
                chk("wd.fire.timeout", 32'(a_to), 1);
                chk("wd.fire.m0_ack", 32'(a_m0_ack), 0);
            end
            tick();
        end
        #1;
        chk("wd.abort.grant", 32'(a_grant), 32'h2);
        chk("wd.abort.s_cyc", 32'(a_s_cyc), 0);
        chk("wd.abort.m1_ack", 32'(a_m1_ack), 0);
        chk("wd.abort.timeout", 32'(a_to), 1);
        tick();
        m1_cyc = 0; m1_stb = 0;
        #1 chk("wd.drop.grant", 32'(a_grant), 32'h2);
        tick();
        #1;
        chk("wd.released.grant", 32'(a_grant), 0);
        chk("wd.sticky.timeout", 32'(a_to), 1);
        chk("wd.b.timeout", 32'(b_to), 0);
        to_clr = 1;
        tick();
        to_clr = 0;
        #1 chk("wd.cleared.timeout", 32'(a_to), 0);
        tick();

        // ack exactly on the expiry cycle
        m1_cyc = 1; m1_stb = 1;
        tick();
        for (int k = 1; k < 16; k++) tick();
        s_ack = 1; s_dat = 8'h77;
        #1;
        chk("edge.m1_ack", 32'(a_m1_ack), 1);
        chk("edge.m1_dat", 32'(a_m1_dat), 32'h77);
        chk("edge.s_cyc", 32'(a_s_cyc), 1);
        chk("edge.timeout", 32'(a_to), 0);
        tick();
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        #1 chk("edge.after.timeout", 32'(a_to), 0);
        chk("edge.after.grant", 32'(a_grant), 32'h2);
        tick();
        #1 chk("edge.idle.timeout", 32'(a_to), 0);
        tick();

        // watchdog disabled: 100 silent cycles, never a forced ack
        m1_cyc = 1; m1_stb = 1;
        tick();
        nacks = 0; nbadg = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (b_m1_ack) nacks++;
            if (b_grant != 2'b10) nbadg++;
            tick();
        end
        chk("wd0.forced_acks", 32'(nacks), 0);
        chk("wd0.grant_lost", 32'(nbadg), 0);
        chk("wd0.s_cyc", 32'(b_s_cyc), 1);
        m1_cyc = 0; m1_stb = 0;
        tick(); tick();
        to_clr = 1;
        tick();
        to_clr = 0;

        // m0 completes a transfer so last-served = m0 before the reset test
        m0_cyc = 1; m0_stb = 1;
        tick();
        s_ack = 1;
        #1 chk("pre.m0_ack", 32'(a_m0_ack), 1);
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        tick(); tick();

        // async reset in the middle of an m0 write
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_dat = 8'h5C;
        tick();
        s_ack = 1;
        #1;
        chk("arst.pre.grant", 32'(a_grant), 32'h1);
        chk("arst.pre.s_we", 32'(a_s_we), 1);
        chk("arst.pre.m0_ack", 32'(a_m0_ack), 1);
        #2 rst_n = 0;
        #1;
        chk("arst.grant", 32'(a_grant), 0);
        chk("arst.s_cyc", 32'(a_s_cyc), 0);
        chk("arst.s_stb", 32'(a_s_stb), 0);
        chk("arst.s_we", 32'(a_s_we), 0);
        chk("arst.s_addr", 32'(a_s_addr), 0);
        chk("arst.s_dat", 32'(a_s_dat), 0);
        chk("arst.m0_ack", 32'(a_m0_ack), 0);
        chk("arst.m1_ack", 32'(a_m1_ack), 0);
        idle_in();
        @(negedge clk);
        rst_n = 1;
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        #1 chk("arst.tie.idle", 32'(a_grant), 0);
        tick();
        #1 chk("arst.tie.grant", 32'(a_grant), 32'h1);
        tick();

        // randomized traffic against the reference model
        idle_in();
        rst_n = 0;
        tick();
        rst_n = 1;
        ma = '{-1, 1'b0, 1, 0, 1'b0};
        mb = ma;
        rc[0] = 0; rc[1] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mode = (cyc / 250) % 2;
            for (int p = 0; p < 2; p++) begin
                if (rc[p]) begin
                    if ($urandom % ((mode != 0) ? 30 : 8) == 0) rc[p] = 0;
                end else if ($urandom % 4 == 0) begin
                    rc[p] = 1;
                end
            end
            m0_cyc = rc[0]; m1_cyc = rc[1];
            m0_stb = rc[0] && (mode != 0 || $urandom % 4 != 0);
            m1_stb = rc[1] && (mode != 0 || $urandom % 4 != 0);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_addr = 24'($urandom); m1_addr = 24'($urandom);
            m0_dat = 8'($urandom); m1_dat = 8'($urandom);
            s_dat = 8'($urandom);
            s_ack = (mode != 0) ? ($urandom % 40 == 0) : ($urandom % 3 == 0);
            to_clr = ($urandom % 12 == 0);
            #1;
            model_eval(ma, 16, ea, na);
            model_eval(mb, 0, eb, nb);
            cmp_obs("rnd.a", oa, ea);
            cmp_obs("rnd.b", ob, eb);
            ma = na;
            mb = nb;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
